// File: rtl/fmac_pkg.sv
// Shared TX-path definitions for the LeWiz MAC core.
// Beat layout, byte-lane anchors and SA inserter state encodings.
package fmac_pkg;

   localparam int FMAC_DW   = 64;
   localparam int FMAC_MODW = 3;
   localparam int FMAC_ERRW = 2;

   localparam int SA_W0_LSB = 0;
   localparam int SA_W1_MSB = 63;

   typedef enum logic [2:0] {
      SA_IDLE = 3'b001,
      SA_HDR1 = 3'b010,
      SA_BODY = 3'b100
   } sa_state_e;

   typedef struct packed {
      logic [FMAC_DW-1:0]   data;
      logic                 sop;
      logic                 eop;
      logic [FMAC_MODW-1:0] mod;
   } tx_beat_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fmac_tx_pipe_reg.sv
// Valid/ready output register slice for TX beats.
// Error flags ride along as single-cycle pulses tied to the loaded beat.
module fmac_tx_pipe_reg
   import fmac_pkg::*;
#(
   parameter int ERRW = FMAC_ERRW
)
(
   input  logic            clk,
   input  logic            rst_,
   input  logic            in_vld,
   output logic            in_rdy,
   input  tx_beat_t        in_beat,
   input  logic [ERRW-1:0] in_err,
   output logic            out_vld,
   output tx_beat_t        out_beat,
   output logic [ERRW-1:0] out_err,
   input  logic            out_rdy
);

   logic load;

   assign in_rdy = !out_vld | out_rdy;
   assign load   = in_vld & in_rdy;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         out_vld  <= 1'b0;
         out_beat <= '0;
         out_err  <= '0;
      end else begin
         // Flags pulse once, even if the beat then stalls
         out_err <= load ? in_err : '0;
         if (load) begin
            out_vld  <= 1'b1;
            out_beat <= in_beat;
         end else if (out_rdy) begin
            out_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fmac_saddr_insert.sv
// TX source-address inserter: overwrites wire bytes 6..11
// with the station address captured at each frame's SOP.
module fmac_saddr_insert
   import fmac_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_,
   input  logic                 saddr_ins_en,
   input  logic [47:0]          cfg_saddr,
   input  logic [FMAC_DW-1:0]   tx_in_data,
   input  logic                 tx_in_vld,
   input  logic                 tx_in_sop,
   input  logic                 tx_in_eop,
   input  logic [FMAC_MODW-1:0] tx_in_mod,
   output logic                 tx_in_rdy,
   output logic [FMAC_DW-1:0]   tx_out_data,
   output logic                 tx_out_vld,
   output logic                 tx_out_sop,
   output logic                 tx_out_eop,
   output logic [FMAC_MODW-1:0] tx_out_mod,
   input  logic                 tx_out_rdy,
   output logic [15:0]          saddr_ins_cnt,
   output logic                 saddr_short_err,
   output logic                 saddr_proto_err
);

   sa_state_e      state;
   logic           ins_act;
   logic [31:0]    saddr_shadow;
   logic           beat_acc;
   logic [FMAC_DW-1:0] data_d;
   logic           short_d;
   logic           proto_d;
   tx_beat_t       in_beat;
   tx_beat_t       out_beat;
   logic [FMAC_ERRW-1:0] out_err;

   assign beat_acc = tx_in_vld & tx_in_rdy;

   always_comb begin
      data_d  = tx_in_data;
      short_d = 1'b0;
      proto_d = 1'b0;
      if (tx_in_sop) begin
         proto_d = (state != SA_IDLE);
         short_d = tx_in_eop;
         if (saddr_ins_en)
            data_d[SA_W0_LSB +: 16] = cfg_saddr[47:32];
      end else begin
         unique case (1'b1)
            state[0]: proto_d = 1'b1;
            state[1]: begin
               // Short EOP here still gets all four bytes
               if (ins_act)
                  data_d[SA_W1_MSB -: 32] = saddr_shadow;
            end
            state[2]: data_d = tx_in_data;
            default:  data_d = tx_in_data;
         endcase
      end
   end

   always_comb begin
      in_beat      = '0;
      in_beat.data = data_d;
      in_beat.sop  = tx_in_sop;
      in_beat.eop  = tx_in_eop;
      in_beat.mod  = tx_in_mod;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state         <= SA_IDLE;
         ins_act       <= 1'b0;
         saddr_shadow  <= '0;
         saddr_ins_cnt <= '0;
      end else if (beat_acc) begin
         if (tx_in_sop) begin
            ins_act      <= saddr_ins_en;
            saddr_shadow <= cfg_saddr[31:0];
            if (saddr_ins_en)
               saddr_ins_cnt <= sat_inc16(saddr_ins_cnt);
            state <= tx_in_eop ? SA_IDLE : SA_HDR1;
         end else begin
            unique case (1'b1)
               state[0]: state <= SA_IDLE;
               state[1]: state <= tx_in_eop ? SA_IDLE : SA_BODY;
               state[2]: state <= tx_in_eop ? SA_IDLE : SA_BODY;
               default:  state <= SA_IDLE;
            endcase
         end
      end
   end

   fmac_tx_pipe_reg #(
      .ERRW (FMAC_ERRW)
   ) u_out (
      .clk      (clk),
      .rst_     (rst_),
      .in_vld   (tx_in_vld),
      .in_rdy   (tx_in_rdy),
      .in_beat  (in_beat),
      .in_err   ({short_d, proto_d}),
      .out_vld  (tx_out_vld),
      .out_beat (out_beat),
      .out_err  (out_err),
      .out_rdy  (tx_out_rdy)
   );

   assign tx_out_data     = out_beat.data;
   assign tx_out_sop      = out_beat.sop;
   assign tx_out_eop      = out_beat.eop;
   assign tx_out_mod      = out_beat.mod;
   assign saddr_short_err = out_err[1];
   assign saddr_proto_err = out_err[0];

endmodule

// File: tb/tb_fmac_saddr_insert.sv
// Directed bench for the TX source-address inserter.
// Vector table plus stall, reset and saturation sequences.
module tb_fmac_saddr_insert;

   localparam logic [47:0] SA_A = 48'h0012_3456_789A;
   localparam logic [47:0] SA_B = 48'hA1A2_A3A4_A5A6;

   logic        clk = 1'b0;
   logic        rst_;
   logic        saddr_ins_en;
   logic [47:0] cfg_saddr;
   logic [63:0] tx_in_data;
   logic        tx_in_vld;
   logic        tx_in_sop;
   logic        tx_in_eop;
   logic [2:0]  tx_in_mod;
   logic        tx_in_rdy;
   logic [63:0] tx_out_data;
   logic        tx_out_vld;
   logic        tx_out_sop;
   logic        tx_out_eop;
   logic [2:0]  tx_out_mod;
   logic        tx_out_rdy;
   logic [15:0] saddr_ins_cnt;
   logic        saddr_short_err;
   logic        saddr_proto_err;

   int checks   = 0;
   int failures = 0;

   bit bp_on   = 1'b0;
   bit hold_lo = 1'b0;
   bit mon_on  = 1'b0;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        en;
      logic [47:0] cfg;
      logic [63:0] din;
      logic [63:0] dout;
      logic        se;
      logic        pe;
      logic [15:0] cnt;
   } vec_t;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
   } beat_t;

   vec_t  vq[$];
   beat_t exp_q[$];
   int    rx_cnt = 0;

   fmac_saddr_insert dut (
      .clk             (clk),
      .rst_            (rst_),
      .saddr_ins_en    (saddr_ins_en),
      .cfg_saddr       (cfg_saddr),
      .tx_in_data      (tx_in_data),
      .tx_in_vld       (tx_in_vld),
      .tx_in_sop       (tx_in_sop),
      .tx_in_eop       (tx_in_eop),
      .tx_in_mod       (tx_in_mod),
      .tx_in_rdy       (tx_in_rdy),
      .tx_out_data     (tx_out_data),
      .tx_out_vld      (tx_out_vld),
      .tx_out_sop      (tx_out_sop),
      .tx_out_eop      (tx_out_eop),
      .tx_out_mod      (tx_out_mod),
      .tx_out_rdy      (tx_out_rdy),
      .saddr_ins_cnt   (saddr_ins_cnt),
      .saddr_short_err (saddr_short_err),
      .saddr_proto_err (saddr_proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] act,
                        input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void av(logic sop, logic eop, logic [2:0] mod,
                              logic en, logic [47:0] cfg,
                              logic [63:0] din, logic [63:0] dout,
                              logic se, logic pe, logic [15:0] cnt);
      vec_t v;
      v.sop = sop; v.eop = eop; v.mod = mod; v.en = en;
      v.cfg = cfg; v.din = din; v.dout = dout;
      v.se = se; v.pe = pe; v.cnt = cnt;
      vq.push_back(v);
   endfunction

   task automatic idle_inputs();
      tx_in_vld    = 1'b0;
      tx_in_sop    = 1'b0;
      tx_in_eop    = 1'b0;
      tx_in_mod    = 3'd0;
      tx_in_data   = '0;
      saddr_ins_en = 1'b0;
      cfg_saddr    = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
   endtask

   // Beat is driven at negedge and accepted at the following posedge
   task automatic drive_beat(input logic [63:0] d, input logic sop,
                             input logic eop, input logic [2:0] mod,
                             input logic en, input logic [47:0] cfg);
      int n;
      @(negedge clk);
      tx_in_data   = d;
      tx_in_sop    = sop;
      tx_in_eop    = eop;
      tx_in_mod    = mod;
      saddr_ins_en = en;
      cfg_saddr    = cfg;
      tx_in_vld    = 1'b1;
      n = 0;
      while (!tx_in_rdy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         failures++;
         $display("FAIL drive_timeout actual=stalled required=accept");
      end
      @(posedge clk);
   endtask

   initial begin
      tx_out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hold_lo)
            tx_out_rdy = 1'b0;
         else if (bp_on)
            tx_out_rdy = ($urandom_range(0, 1) == 1);
         else
            tx_out_rdy = 1'b1;
      end
   end

   initial begin
      bit    stall_pend = 1'b0;
      beat_t held;
      beat_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (stall_pend)
               check("stall_hold",
                     96'({tx_out_vld, tx_out_data, tx_out_sop,
                          tx_out_eop, tx_out_mod}),
                     96'({1'b1, held}));
            if (tx_out_vld)
               check("bp_err_flags",
                     96'({saddr_short_err, saddr_proto_err}), 96'(0));
            stall_pend = 1'b0;
            if (tx_out_vld && tx_out_rdy) begin
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL bp_extra_beat actual=%0h required=none",
                           tx_out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("bp_beat",
                        96'({tx_out_data, tx_out_sop, tx_out_eop,
                             tx_out_mod}),
                        96'(e));
                  rx_cnt++;
               end
            end else if (tx_out_vld) begin
               stall_pend = 1'b1;
               held = {tx_out_data, tx_out_sop, tx_out_eop, tx_out_mod};
            end
         end
      end
   end

   initial begin
      int total;
      int n;
      rst_ = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("reset_ctl",
            96'({tx_out_vld, tx_out_sop, tx_out_eop, tx_out_mod,
                 saddr_short_err, saddr_proto_err, saddr_ins_cnt,
                 tx_in_rdy}),
            96'({1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0, 1'b1}));
      check("reset_data", 96'(tx_out_data), 96'(0));
      rst_ = 1'b1;

      // basic insert
      av(1, 0, 0, 1, SA_A, 64'hFFFF_FFFF_FFFF_AAAA,
         64'hFFFF_FFFF_FFFF_0012, 0, 0, 1);
      av(0, 0, 0, 1, SA_A, 64'hBBBB_BBBB_CCCC_CCCC,
         64'h3456_789A_CCCC_CCCC, 0, 0, 1);
      av(0, 1, 4, 1, SA_A, 64'h1111_2222_3333_4444,
         64'h1111_2222_3333_4444, 0, 0, 1);
      // disabled
      av(1, 0, 0, 0, SA_A, 64'hFFFF_FFFF_FFFF_AAAA,
         64'hFFFF_FFFF_FFFF_AAAA, 0, 0, 1);
      av(0, 0, 0, 0, SA_A, 64'hBBBB_BBBB_CCCC_CCCC,
         64'hBBBB_BBBB_CCCC_CCCC, 0, 0, 1);
      av(0, 1, 4, 0, SA_A, 64'h1111_2222_3333_4444,
         64'h1111_2222_3333_4444, 0, 0, 1);
      // cfg and enable change after SOP
      av(1, 0, 0, 1, SA_A, 64'hFFFF_FFFF_FFFF_AAAA,
         64'hFFFF_FFFF_FFFF_0012, 0, 0, 2);
      av(0, 0, 0, 0, 48'hFFFF_FFFF_FFFF, 64'hBBBB_BBBB_CCCC_CCCC,
         64'h3456_789A_CCCC_CCCC, 0, 0, 2);
      av(0, 1, 0, 0, 48'hFFFF_FFFF_FFFF, 64'h5555_5555_5555_5555,
         64'h5555_5555_5555_5555, 0, 0, 2);
      // single-beat frame
      av(1, 1, 2, 1, SA_B, 64'h0123_4567_89AB_CDEF,
         64'h0123_4567_89AB_A1A2, 1, 0, 3);
      // EOP in HDR1 with mod 2
      av(1, 0, 0, 1, SA_B, 64'h0,
         64'h0000_0000_0000_A1A2, 0, 0, 4);
      av(0, 1, 2, 1, SA_B, 64'h7777_7777_7777_7777,
         64'hA3A4_A5A6_7777_7777, 0, 0, 4);
      // SOP in BODY
      av(1, 0, 0, 1, SA_A, 64'h0,
         64'h0000_0000_0000_0012, 0, 0, 5);
      av(0, 0, 0, 1, SA_A, 64'h1,
         64'h3456_789A_0000_0001, 0, 0, 5);
      av(0, 0, 0, 1, SA_A, 64'h2, 64'h2, 0, 0, 5);
      av(1, 0, 0, 1, SA_B, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_A1A2, 0, 1, 6);
      av(0, 0, 0, 1, SA_A, 64'hEEEE_EEEE_EEEE_EEEE,
         64'hA3A4_A5A6_EEEE_EEEE, 0, 0, 6);
      av(0, 1, 0, 1, SA_A, 64'h3, 64'h3, 0, 0, 6);
      // non-SOP in IDLE
      av(0, 0, 0, 1, SA_A, 64'hDEAD_BEEF_DEAD_BEEF,
         64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 6);
      av(0, 1, 5, 1, SA_A, 64'hCAFE_CAFE_CAFE_CAFE,
         64'hCAFE_CAFE_CAFE_CAFE, 0, 1, 6);
      // SOP in HDR1 relatches a disabled insert
      av(1, 0, 0, 1, SA_A, 64'h0,
         64'h0000_0000_0000_0012, 0, 0, 7);
      av(1, 0, 0, 0, SA_A, 64'h0123_4567_89AB_CDEF,
         64'h0123_4567_89AB_CDEF, 0, 1, 7);
      av(0, 1, 0, 1, SA_B, 64'h9999_9999_9999_9999,
         64'h9999_9999_9999_9999, 0, 0, 7);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         tx_in_vld    = 1'b1;
         tx_in_sop    = vq[i].sop;
         tx_in_eop    = vq[i].eop;
         tx_in_mod    = vq[i].mod;
         saddr_ins_en = vq[i].en;
         cfg_saddr    = vq[i].cfg;
         tx_in_data   = vq[i].din;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_data", i), 96'(tx_out_data),
               96'(vq[i].dout));
         check($sformatf("vec%0d_ctl", i),
               96'({tx_out_vld, tx_out_sop, tx_out_eop, tx_out_mod,
                    saddr_short_err, saddr_proto_err, saddr_ins_cnt}),
               96'({1'b1, vq[i].sop, vq[i].eop, vq[i].mod,
                    vq[i].se, vq[i].pe, vq[i].cnt}));
      end
      @(negedge clk);
      idle_inputs();

      // random backpressure, 100 frames
      do_reset();
      bp_on  = 1'b1;
      mon_on = 1'b1;
      total  = 0;
      for (int f = 0; f < 100; f++) begin
         logic [47:0] fcfg;
         int          len;
         fcfg = {$urandom_range(0, 65535), $urandom};
         len  = 2 + (f % 4);
         for (int b = 0; b < len; b++) begin
            beat_t       e;
            logic [63:0] d;
            logic        eop;
            logic [2:0]  mod;
            logic [47:0] c;
            d   = {$urandom, $urandom};
            eop = (b == len - 1);
            mod = eop ? 3'(f % 8) : 3'd0;
            c   = (b == 0) ? fcfg : {$urandom_range(0, 65535), $urandom};
            e.d = d;
            if (b == 0) e.d[15:0] = fcfg[47:32];
            if (b == 1) e.d[63:32] = fcfg[31:0];
            e.sop = (b == 0);
            e.eop = eop;
            e.mod = mod;
            exp_q.push_back(e);
            total++;
            drive_beat(d, b == 0, eop, mod,
                       (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)), c);
         end
      end
      @(negedge clk);
      idle_inputs();
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("bp_drain", 96'(exp_q.size()), 96'(0));
      check("bp_rx_count", 96'(rx_cnt), 96'(total));
      check("bp_ins_cnt", 96'(saddr_ins_cnt), 96'(100));
      bp_on = 1'b0;
      repeat (3) @(negedge clk);
      mon_on = 1'b0;

      // reset in the middle of a stalled frame
      hold_lo = 1'b1;
      @(posedge clk);
      #2;
      drive_beat(64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 0, 1, SA_A);
      @(negedge clk);
      idle_inputs();
      check("mid_pre_reset",
            96'({tx_out_vld, tx_out_sop, tx_out_data}),
            96'({1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_0012}));
      #2;
      rst_ = 1'b0;
      #1;
      check("mid_async_ctl",
            96'({tx_out_vld, tx_out_sop, tx_out_eop, tx_out_mod,
                 saddr_short_err, saddr_proto_err, saddr_ins_cnt}),
            96'(0));
      check("mid_async_data", 96'(tx_out_data), 96'(0));
      @(negedge clk);
      @(negedge clk);
      rst_    = 1'b1;
      hold_lo = 1'b0;
      @(posedge clk);
      #2;
      drive_beat(64'h1234_5678_9ABC_DEF0, 0, 0, 0, 1, SA_B);
      #1;
      check("mid_rest_proto",
            96'({tx_out_vld, tx_out_data, saddr_proto_err,
                 saddr_short_err}),
            96'({1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0}));
      @(negedge clk);
      idle_inputs();

      // counter saturation with back-to-back single-beat frames
      do_reset();
      tx_in_vld    = 1'b1;
      tx_in_sop    = 1'b1;
      tx_in_eop    = 1'b1;
      tx_in_mod    = 3'd0;
      saddr_ins_en = 1'b1;
      cfg_saddr    = SA_A;
      tx_in_data   = 64'h5A5A_5A5A_5A5A_5A5A;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      check("sat_fffe", 96'(saddr_ins_cnt), 96'(16'hFFFE));
      @(posedge clk);
      @(negedge clk);
      check("sat_ffff", 96'(saddr_ins_cnt), 96'(16'hFFFF));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sat_hold",
            96'({saddr_ins_cnt, saddr_short_err, tx_out_data}),
            96'({16'hFFFF, 1'b1, 64'h5A5A_5A5A_5A5A_0012}));
      idle_inputs();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
